stopwatch_ctrl: RTL and testbench

Control and counting core of the stopwatch. It turns debounced start/stop, lap and clear button pulses into a run/pause/lap state machine, and it gates and restarts the 0.1 s timebase. It accumulates elapsed time as BCD digits (MM:SS.t) and presents either the live count or a frozen lap value to the display driver.

---
 rtl/stopwatch_ctrl.sv | 104 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap FSM with timebase gating and an MM:SS.t BCD counter.
module stopwatch_ctrl #(
    parameter bit TB_CLR_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic        tick,
    output logic        tb_en,
    output logic        tb_clr,
    output logic [19:0] disp,
    output logic        running,
    output logic        frozen,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} state_t;
    state_t state_q, state_d;
    logic ss, lap, accept;
    logic c0, c1, c2, c3, c4;
    logic [3:0] t, so, st, mo, mt;
    logic [19:0] inc, cnt_q, cnt_d, lap_q, lap_d, disp_q, disp_d;
    logic tb_en_q, tb_en_d, tb_clr_q, tb_clr_d, running_q, running_d;
    logic frozen_q, frozen_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        ss      = btn_ss & ~btn_clr;
        lap     = btn_lap & ~btn_clr & ~btn_ss;
        state_d = state_q;
        if (btn_clr) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = ss ? RUNNING : IDLE;
                RUNNING: state_d = ss ? PAUSED : lap ? LAP : RUNNING;
                PAUSED:  state_d = ss ? RUNNING : PAUSED;
                LAP:     state_d = ss ? PAUSED : lap ? RUNNING : LAP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tb_en_d   = (state_d == RUNNING) || (state_d == LAP);
        running_d = tb_en_d;
        frozen_d  = state_d == LAP;
        tb_clr_d  = btn_clr | (TB_CLR_ON_START & (state_q == IDLE) & ss);
    end

    // Saturating compares keep the carry chain safe even from an out-of-range digit.
    assign {mt, mo, st, so, t} = cnt_q;
    assign c0 = t >= 4'd9;
    assign c1 = c0 & (so >= 4'd9);
    assign c2 = c1 & (st >= 4'd5);
    assign c3 = c2 & (mo >= 4'd9);
    assign c4 = c3 & (mt >= 4'd5);
    assign inc = {c4 ? 4'd0 : c3 ? mt + 4'd1 : mt,
                  c3 ? 4'd0 : c2 ? mo + 4'd1 : mo,
                  c2 ? 4'd0 : c1 ? st + 4'd1 : st,
                  c1 ? 4'd0 : c0 ? so + 4'd1 : so,
                  c0 ? 4'd0 : t + 4'd1};

    always_comb begin
        accept = tick & ~btn_clr & ((state_q == RUNNING) || (state_q == LAP));
        cnt_d  = btn_clr ? 20'h0 : accept ? inc : cnt_q;
        ovf_d  = ~btn_clr & (ovf_q | (accept & c4));
        lap_d  = btn_clr ? 20'h0 : (lap && state_q == RUNNING) ? cnt_d : lap_q;
        disp_d = frozen_q ? lap_q : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            lap_q     <= '0;
            disp_q    <= '0;
            tb_en_q   <= 1'b0;
            tb_clr_q  <= 1'b0;
            running_q <= 1'b0;
            frozen_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            tb_en_q   <= tb_en_d;
            tb_clr_q  <= tb_clr_d;
            running_q <= running_d;
            frozen_q  <= frozen_d;
            ovf_q     <= ovf_d;
        end
    end

    assign disp    = disp_q;
    assign tb_en   = tb_en_q;
    assign tb_clr  = tb_clr_q;
    assign running = running_q;
    assign frozen  = frozen_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: cycle scoreboard against a decimal-tenths model plus directed checks.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst, btn_ss, btn_lap, btn_clr, tick;
    logic tb_en, tb_clr, running, frozen, ovf;
    logic [19:0] disp;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    int n_tests = 0, n_fail = 0;
    int m_st, m_cnt, m_lap;
    bit m_ovf, m_clr;
    logic [19:0] m_disp;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .tick(tick), .tb_en(tb_en), .tb_clr(tb_clr), .disp(disp), .running(running),
        .frozen(frozen), .ovf(ovf)
    );

    assign obs = {disp, tb_en, tb_clr, running, frozen, ovf};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] bcd(input int c);
        int s, m;
        s = (c / 10) % 60;
        m = c / 600;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c % 10)};
    endfunction

    task automatic step(input bit r, input bit ss, input bit lp, input bit cl, input bit tk);
        logic [19:0] nd;
        bit run;
        @(negedge clk);
        rst = r; btn_ss = ss; btn_lap = lp; btn_clr = cl; tick = tk;
        if (!r) begin
            m_st = 0; m_cnt = 0; m_lap = 0; m_ovf = 0; m_clr = 0; m_disp = '0;
        end else begin
            nd    = (m_st == 3) ? bcd(m_lap) : bcd(m_cnt);
            run   = (m_st == 1) || (m_st == 3);
            m_clr = 0;
            if (cl) begin
                m_st = 0; m_cnt = 0; m_lap = 0; m_ovf = 0; m_clr = 1;
            end else begin
                if (run && tk) begin
                    m_cnt++;
                    if (m_cnt == 36000) begin m_cnt = 0; m_ovf = 1; end
                end
                if (ss) begin
                    if (m_st == 0) m_clr = 1;
                    m_st = run ? 2 : 1;
                end else if (lp && m_st == 1) begin
                    m_st = 3; m_lap = m_cnt;
                end else if (lp && m_st == 3) m_st = 1;
            end
            m_disp = nd;
        end
        exp_q.push_back({m_disp, (m_st == 1) || (m_st == 3), m_clr,
                         (m_st == 1) || (m_st == 3), m_st == 3, m_ovf});
        @(posedge clk);
        #1;
        check("cycle", obs, exp_q.pop_front());
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 1);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0; btn_ss = 0; btn_lap = 0; btn_clr = 0; tick = 0;
        repeat (3) step(0, 0, 0, 0, 0);
        check("reset_outputs", obs, 25'h0);
        ticks(20);
        check("idle_disp", disp, 20'h00000);
        check("idle_tb_en", tb_en, 0);
        check("idle_ovf", ovf, 0);

        step(1, 1, 0, 0, 0);
        check("start_tb_clr", tb_clr, 1);
        check("start_running", running, 1);
        idle();
        check("start_tb_clr_one", tb_clr, 0);
        ticks(125);
        idle();
        check("count_125", disp, 20'h00125);

        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        ticks(37);
        step(1, 1, 0, 0, 0);
        check("pause_tb_en", tb_en, 0);
        ticks(10);
        step(1, 1, 0, 0, 0);
        check("resume_no_tb_clr", tb_clr, 0);
        ticks(5);
        idle();
        check("pause_resume", disp, 20'h00042);

        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        ticks(30);
        step(1, 0, 1, 0, 0);
        ticks(50);
        check("lap_hold", disp, 20'h00030);
        check("lap_frozen", frozen, 1);
        step(1, 0, 1, 0, 0);
        idle();
        check("lap_release", disp, 20'h00080);
        check("lap_unfrozen", frozen, 0);

        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        ticks(36000);
        idle();
        check("wrap_disp", disp, 20'h00000);
        check("wrap_ovf", ovf, 1);
        check("wrap_running", running, 1);
        step(1, 0, 0, 1, 0);
        check("clr_ovf", ovf, 0);
        check("clr_idle", running, 0);

        step(1, 1, 0, 0, 0);
        ticks(99);
        step(1, 1, 0, 1, 1);
        check("clr_ss_tick_state", running, 0);
        idle();
        check("clr_ss_tick_disp", disp, 20'h00000);

        step(1, 1, 0, 0, 0);
        ticks(4);
        step(1, 1, 0, 0, 1);
        check("ss_tick_paused", running, 0);
        idle();
        check("ss_tick_disp", disp, 20'h00005);

        for (int i = 0; i < 600; i++)
            step(1, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);
        step(0, 1, 0, 0, 1);
        check("mid_reset", obs, 25'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
